regfile_read_arbiter: RTL and testbench

Shares the single register-file read port (5-bit `ctrl_readReg` select, 32-bit read data) among up to NUM_REQ requesters, for example decode operand fetch, a second operand fetch and a debug/scan port. Arbitration is round-robin with a valid/ready handshake. Every granted read is captured into a per-requester response register with its own valid/ready handshake. Register 0 reads return zero, and a same-cycle write to the read register is forwarded. The block sits between the requesters and the register file's read-port decoder.

---
 rtl/regfile_read_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_read_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
//
// Shares the single register-file read port among NUM_REQ requesters. Each
// cycle at most one eligible requester is granted (round-robin). The granted
// requester's register select drives the read port, and the value is captured
// into that requester's response register at the end of the cycle. Register 0
// reads as zero, and a write to the selected register in the grant cycle is
// forwarded in place of the stale read data.
//
// Ports
//   clock            : rising-edge clock
//   ctrl_reset_n     : asynchronous active-low reset
//   req_valid        : per-requester read request
//   req_reg          : per-requester register select, slice i at [i*REG_W +: REG_W]
//   req_ready        : one-hot grant (combinational), all zero when idle/reset
//   resp_valid       : per-requester response held (registered)
//   resp_data        : per-requester response data, slice i at [i*DATA_W +: DATA_W]
//   resp_ready       : requester accepts its response
//   ctrl_readReg     : select driven to the register-file read port
//   read_data        : register-file read data for ctrl_readReg, same cycle
//   ctrl_writeEnable : snooped register-file write enable
//   ctrl_writeReg    : snooped write select
//   data_writeReg    : snooped write data
// -----------------------------------------------------------------------------
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_W-1:0]  req_reg,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [NUM_REQ*DATA_W-1:0] resp_data,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [REG_W-1:0]          ctrl_readReg,
    input  logic [DATA_W-1:0]         read_data,
    input  logic                      ctrl_writeEnable,
    input  logic [REG_W-1:0]          ctrl_writeReg,
    input  logic [DATA_W-1:0]         data_writeReg
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]          rr_ptr_q;
    logic [PTR_W-1:0]          rr_ptr_d;
    logic [NUM_REQ-1:0]        resp_valid_q;
    logic [NUM_REQ-1:0]        resp_valid_d;
    logic [NUM_REQ*DATA_W-1:0] resp_data_q;
    logic [NUM_REQ*DATA_W-1:0] resp_data_d;

    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        grant;
    logic [REG_W-1:0]          sel_reg;
    logic [DATA_W-1:0]         capture_val;

    // A slot that is full and not draining this cycle blocks a new grant;
    // a slot being drained right now is as good as empty.
    assign eligible = req_valid & ~(resp_valid_q & ~resp_ready);

    // Round-robin scan starting at rr_ptr_q. The first eligible index wins
    // and the pointer moves to the slot just past the winner. Reset kills
    // the grant combinationally so nothing reaches the read port.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        logic [PTR_W:0]   nxt;
        logic             found;
        grant    = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        nxt      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                nxt        = {1'b0, idx} + (PTR_W + 1)'(1);
                if (nxt == (PTR_W + 1)'(NUM_REQ)) begin
                    nxt = '0;
                end
                rr_ptr_d = nxt[PTR_W-1:0];
            end
        end
        if (!ctrl_reset_n) begin
            grant    = '0;
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Select of the granted requester; zero when nobody is granted.
    always_comb begin
        sel_reg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_reg = req_reg[i*REG_W +: REG_W];
            end
        end
    end

    // Value to capture: r0 is hardwired zero, and a write landing on the
    // selected register this very cycle beats the (old) read-port value.
    always_comb begin
        if (sel_reg == '0) begin
            capture_val = '0;
        end else if (ctrl_writeEnable && (ctrl_writeReg == sel_reg)) begin
            capture_val = data_writeReg;
        end else begin
            capture_val = read_data;
        end
    end

    // Response slots: a grant refills the slot (even if it is draining in
    // the same cycle); otherwise a completed handshake empties it while the
    // data register keeps its last value.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                resp_valid_d[i]                = 1'b1;
                resp_data_d[i*DATA_W +: DATA_W] = capture_val;
            end else if (resp_valid_q[i] && resp_ready[i]) begin
                resp_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready    = grant;
    assign ctrl_readReg = sel_reg;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_arbiter
//
// Directed bench for regfile_read_arbiter (NUM_REQ=4). Stimulus pushes the
// hand-computed response for every expected grant into a per-requester queue;
// a separate monitor pops and compares whenever a response is handed over
// (resp_valid && resp_ready). Grant and port-select values are checked in the
// cycle they are driven.
// -----------------------------------------------------------------------------
module tb_regfile_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;

    logic                      clock = 1'b0;
    logic                      ctrlResetN;
    logic [NUM_REQ-1:0]        reqValid;
    logic [NUM_REQ*REG_W-1:0]  reqReg;
    logic [NUM_REQ-1:0]        reqReady;
    logic [NUM_REQ-1:0]        respValid;
    logic [NUM_REQ*DATA_W-1:0] respData;
    logic [NUM_REQ-1:0]        respReady;
    logic [REG_W-1:0]          ctrlReadReg;
    logic [DATA_W-1:0]         readData;
    logic                      writeEnable;
    logic [REG_W-1:0]          writeReg;
    logic [DATA_W-1:0]         writeData;

    logic [DATA_W-1:0]         regFile [32];
    logic [DATA_W-1:0]         expQ [NUM_REQ][$];

    int testsRun    = 0;
    int testsFailed = 0;

    // 10-unit clock; inputs change 1 unit after the rising edge and all
    // sampling happens on the falling edge.
    always #5 clock = ~clock;

    // Behavioural register file: combinational read of the selected register.
    assign readData = regFile[ctrlReadReg];

    regfile_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REG_W   (REG_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrlResetN),
        .req_valid        (reqValid),
        .req_reg          (reqReg),
        .req_ready        (reqReady),
        .resp_valid       (respValid),
        .resp_data        (respData),
        .resp_ready       (respReady),
        .ctrl_readReg     (ctrlReadReg),
        .read_data        (readData),
        .ctrl_writeEnable (writeEnable),
        .ctrl_writeReg    (writeReg),
        .data_writeReg    (writeData)
    );

    // One comparison: counts it, reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [NUM_REQ*REG_W-1:0] packRegs(input logic [4:0] r0, input logic [4:0] r1,
                                                          input logic [4:0] r2, input logic [4:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    // Drives a complete input vector just after the next rising edge.
    task automatic applyStimulus(input logic [3:0] valid, input logic [19:0] regs,
                                 input logic [3:0] ready, input logic we,
                                 input logic [4:0] wreg, input logic [31:0] wdata);
        @(posedge clock);
        #1;
        reqValid    = valid;
        reqReg      = regs;
        respReady   = ready;
        writeEnable = we;
        writeReg    = wreg;
        writeData   = wdata;
    endtask

    // One cycle of stimulus: queue the response expected from the grant,
    // then check the grant and read-port select mid-cycle.
    task automatic step(input string name, input logic [3:0] valid, input logic [19:0] regs,
                        input logic [3:0] ready, input logic we, input logic [4:0] wreg,
                        input logic [31:0] wdata, input logic [3:0] expGrant,
                        input logic [4:0] expSel, input logic [31:0] expData);
        applyStimulus(valid, regs, ready, we, wreg, wdata);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (expGrant[i]) expQ[i].push_back(expData);
        end
        @(negedge clock);
        checkOutput({name, " req_ready"}, {28'd0, reqReady}, {28'd0, expGrant});
        checkOutput({name, " readReg"}, {27'd0, ctrlReadReg}, {27'd0, expSel});
    endtask

    task automatic idle(input string name);
        step(name, 4'b0000, '0, 4'b1111, 1'b0, 5'd0, 32'd0, 4'b0000, 5'd0, 32'd0);
    endtask

    // Monitor: every handed-over response is matched against its queue.
    always @(negedge clock) begin : monitor
        logic [DATA_W-1:0] expVal;
        if (ctrlResetN === 1'b1) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (respValid[i] && respReady[i]) begin
                    if (expQ[i].size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL resp%0d unexpected: got 0x%08h, expected no response",
                                 i, respData[i*DATA_W +: DATA_W]);
                    end else begin
                        expVal = expQ[i].pop_front();
                        checkOutput($sformatf("resp%0d data", i), respData[i*DATA_W +: DATA_W], expVal);
                    end
                end
            end
        end
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [3:0] grantSeq [6];
        logic [4:0] selSeq [6];
        for (int i = 0; i < 32; i++) regFile[i] = 32'h1000_0000 + 32'(i);
        regFile[0]  = 32'hFFFF_FFFF;
        regFile[5]  = 32'hDEAD_BEEF;
        regFile[7]  = 32'h0000_0000;
        regFile[20] = 32'h2020_2020;
        regFile[21] = 32'h2121_2121;

        // Reset values, with every requester asking to be served.
        ctrlResetN  = 1'b0;
        reqValid    = 4'b1111;
        reqReg      = packRegs(5'd1, 5'd2, 5'd3, 5'd4);
        respReady   = 4'b1111;
        writeEnable = 1'b0;
        writeReg    = '0;
        writeData   = '0;
        #12;
        checkOutput("reset resp_valid", {28'd0, respValid}, 32'd0);
        checkOutput("reset resp_data", {31'd0, |respData}, 32'd0);
        checkOutput("reset req_ready", {28'd0, reqReady}, 32'd0);
        checkOutput("reset readReg", {27'd0, ctrlReadReg}, 32'd0);
        reqValid = 4'b0000;
        @(negedge clock);
        ctrlResetN = 1'b1;

        // Single read of r5, response one cycle later.
        step("single", 4'b0001, packRegs(5'd5, 5'd0, 5'd0, 5'd0), 4'b1111, 1'b0, 5'd0, 32'd0,
             4'b0001, 5'd5, 32'hDEAD_BEEF);
        idle("single next");
        checkOutput("single resp_valid", {31'd0, respValid[0]}, 32'd1);

        // r0 reads zero although the read port shows all ones.
        step("zero", 4'b0100, packRegs(5'd0, 5'd0, 5'd0, 5'd0), 4'b1111, 1'b0, 5'd0, 32'd0,
             4'b0100, 5'd0, 32'h0000_0000);

        // Same-cycle write to r7 is forwarded; a write one cycle later is not.
        step("fwd", 4'b1000, packRegs(5'd0, 5'd0, 5'd0, 5'd7), 4'b1111, 1'b1, 5'd7, 32'h1234_5678,
             4'b1000, 5'd7, 32'h1234_5678);
        step("fwd late", 4'b0000, packRegs(5'd0, 5'd0, 5'd0, 5'd7), 4'b1111, 1'b1, 5'd7, 32'hCAFE_F00D,
             4'b0000, 5'd0, 32'd0);

        // A write to r0 must not leak into an r0 read.
        step("fwd r0", 4'b0001, packRegs(5'd0, 5'd0, 5'd0, 5'd0), 4'b1111, 1'b1, 5'd0, 32'hAAAA_5555,
             4'b0001, 5'd0, 32'h0000_0000);
        idle("fwd r0 next");

        // Fresh reset, then round-robin with everyone continuously valid.
        @(posedge clock);
        #2 ctrlResetN = 1'b0;
        @(posedge clock);
        #2 ctrlResetN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step($sformatf("rr%0d", k), 4'b1111, packRegs(5'd8, 5'd9, 5'd10, 5'd11), 4'b1111,
                 1'b0, 5'd0, 32'd0, 4'(1 << (k % 4)), 5'(8 + (k % 4)), 32'h1000_0008 + 32'(k % 4));
        end
        idle("rr drain");

        // Backpressure: requester 1 holds a response and must be skipped.
        step("bp load", 4'b0010, packRegs(5'd8, 5'd20, 5'd10, 5'd11), 4'b1101, 1'b0, 5'd0, 32'd0,
             4'b0010, 5'd20, 32'h2020_2020);
        grantSeq = '{4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
        selSeq   = '{5'd10, 5'd11, 5'd8, 5'd10, 5'd11, 5'd8};
        for (int k = 0; k < 6; k++) begin
            step($sformatf("bp%0d", k), 4'b1111, packRegs(5'd8, 5'd21, 5'd10, 5'd11), 4'b1101,
                 1'b0, 5'd0, 32'd0, grantSeq[k], selSeq[k], 32'h1000_0000 + 32'(selSeq[k]));
        end
        checkOutput("bp held resp_valid", {31'd0, respValid[1]}, 32'd1);
        step("bp release", 4'b1111, packRegs(5'd8, 5'd21, 5'd10, 5'd11), 4'b1111, 1'b0, 5'd0, 32'd0,
             4'b0010, 5'd21, 32'h2121_2121);
        idle("bp after");
        checkOutput("bp refill resp_valid", {31'd0, respValid[1]}, 32'd1);
        idle("bp drain");

        // Build resp_valid = 0110 with rr_ptr = 2, then reset mid-cycle.
        step("pre a", 4'b0100, packRegs(5'd0, 5'd0, 5'd12, 5'd0), 4'b0000, 1'b0, 5'd0, 32'd0,
             4'b0100, 5'd12, 32'h1000_000C);
        step("pre b", 4'b0010, packRegs(5'd0, 5'd13, 5'd12, 5'd0), 4'b0000, 1'b0, 5'd0, 32'd0,
             4'b0010, 5'd13, 32'h1000_000D);
        applyStimulus(4'b1010, packRegs(5'd0, 5'd13, 5'd12, 5'd14), 4'b0000, 1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("pre resp_valid", {28'd0, respValid}, 32'h6);
        checkOutput("pre req_ready", {28'd0, reqReady}, 32'h8);
        #1 ctrlResetN = 1'b0;
        #1;
        checkOutput("midrst resp_valid", {28'd0, respValid}, 32'd0);
        checkOutput("midrst resp_data", {31'd0, |respData}, 32'd0);
        checkOutput("midrst req_ready", {28'd0, reqReady}, 32'd0);
        checkOutput("midrst readReg", {27'd0, ctrlReadReg}, 32'd0);
        for (int i = 0; i < NUM_REQ; i++) expQ[i].delete();
        @(posedge clock);
        #2;
        ctrlResetN = 1'b1;
        respReady  = 4'b1111;
        expQ[1].push_back(32'h1000_000D);
        @(negedge clock);
        checkOutput("post rst req_ready", {28'd0, reqReady}, 32'h2);
        checkOutput("post rst readReg", {27'd0, ctrlReadReg}, 32'd13);
        idle("post rst drain");
        idle("final");

        // Every queued response must have been delivered.
        for (int i = 0; i < NUM_REQ; i++) begin
            checkOutput($sformatf("queue%0d leftover", i), 32'(expQ[i].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
